pipeline_stall_ctrl: RTL and testbench

- Consumes stall and flush requests from the hazard detection unit, the EX-stage branch unit and the data memory.
- Drives the PC and pipeline-register enable, flush and bubble controls, so these are applied cycle-accurately from one place.
- Adds a bounded data-memory wait with a timeout error state and saturating stall/flush performance counters.
- Sits between the hazard/branch logic and the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage RISC-V core.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 13 +
 rtl/pipeline_stall_ctrl_if.sv | 24 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StLstall = 2'd1,
    StMwait  = 2'd2,
    StErr    = 2'd3
  } state_e;

  localparam int unsigned DefaultMemTimeout = 255;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request and pipeline-control bundle between hazard/branch/dmem logic and the stall controller.
interface pipeline_stall_ctrl_if;
  logic load_use_haz;
  logic branch_taken;
  logic dmem_busy;
  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_en;
  logic id_ex_bubble;
  logic ex_mem_en;
  logic mem_wb_bubble;

  // master: the pipeline side raising requests and obeying controls
  modport master (
    output load_use_haz, branch_taken, dmem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble
  );

  modport slave (
    input  load_use_haz, branch_taken, dmem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush/bubble controller for the 5-stage core, with a bounded dmem wait
// and saturating stall/flush performance counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = DefaultMemTimeout,
  parameter int unsigned TO_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave ctrl,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            mem_err_q, mem_err_d;

  logic            freeze, flush, lstall;
  logic [TO_W:0]   wait_inc;
  logic            timeout;
  logic            stall_inc;

  // Request decode with priority ERR > freeze > flush > load stall.
  always_comb begin
    freeze = (state_q != StErr) && ctrl.dmem_busy;
    flush  = (state_q != StErr) && !ctrl.dmem_busy && ctrl.branch_taken;
    lstall = (state_q != StErr) && (state_q != StLstall) && !ctrl.dmem_busy &&
             !ctrl.branch_taken && ctrl.load_use_haz;
  end

  // wait_q counts busy cycles already completed; the current busy cycle makes wait_q + 1.
  assign wait_inc = {1'b0, wait_q} + (TO_W + 1)'(1);
  assign timeout  = wait_inc >= (TO_W + 1)'(MEM_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      StRun, StLstall: begin
        if (ctrl.dmem_busy) begin
          state_d = StMwait;
          wait_d  = TO_W'(1);
        end else if (lstall) begin
          state_d = StLstall;
        end else begin
          state_d = StRun;
        end
      end
      StMwait: begin
        if (ctrl.dmem_busy) begin
          if (timeout) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end else begin
            wait_d = wait_inc[TO_W-1:0];
          end
        end else begin
          wait_d = '0;
          // A load stall taken on the release cycle still masks its stale repeat.
          state_d = lstall ? StLstall : StRun;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    ctrl.pc_en         = 1'b1;
    ctrl.if_id_en      = 1'b1;
    ctrl.if_id_flush   = 1'b0;
    ctrl.id_ex_en      = 1'b1;
    ctrl.id_ex_bubble  = 1'b0;
    ctrl.ex_mem_en     = 1'b1;
    ctrl.mem_wb_bubble = 1'b0;
    if (state_q == StErr) begin
      ctrl.pc_en     = 1'b0;
      ctrl.if_id_en  = 1'b0;
      ctrl.id_ex_en  = 1'b0;
      ctrl.ex_mem_en = 1'b0;
    end else if (freeze) begin
      ctrl.pc_en         = 1'b0;
      ctrl.if_id_en      = 1'b0;
      ctrl.id_ex_en      = 1'b0;
      ctrl.ex_mem_en     = 1'b0;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (flush) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else if (lstall) begin
      ctrl.pc_en        = 1'b0;
      ctrl.if_id_en     = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
    end
  end

  assign stall_inc = !ctrl.pc_en && (state_q != StErr);
  assign mem_err   = mem_err_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (CNT_W=3, MEM_TIMEOUT=4).
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  localparam int unsigned CntW = 3;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
  localparam logic [6:0] CtlFree   = 7'b1101010;
  localparam logic [6:0] CtlFlush  = 7'b1111110;
  localparam logic [6:0] CtlLstall = 7'b0001110;
  localparam logic [6:0] CtlFreeze = 7'b0000001;
  localparam logic [6:0] CtlErr    = 7'b0000000;

  logic            clk;
  logic            reset;
  logic            mem_err;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;
  logic [6:0]      ctl;
  int              checks;
  int              errors;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(
    .CNT_W       (CntW),
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (bus),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  assign ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_bubble,
                bus.ex_mem_en, bus.mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lu, input logic br, input logic busy);
    bus.load_use_haz = lu;
    bus.branch_taken = br;
    bus.dmem_busy    = busy;
  endtask

  // One cycle: drive requests, check the combinational controls, then cross the edge.
  task automatic cyc(input logic lu, input logic br, input logic busy, input logic [6:0] exp,
                     input string tag);
    drive(lu, br, busy);
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #2;
    check("rst_ctl", 32'(ctl), 32'(CtlFree));
    check("rst_cnt", 32'({stall_cnt, flush_cnt}), 32'(0));
    check("rst_err", 32'(mem_err), 32'(0));
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Load-use stall held for two cycles
    cyc(1'b1, 1'b0, 1'b0, CtlLstall, "ls_c0");
    check("ls_state", 32'(dut.state_q), 32'(StLstall));
    cyc(1'b1, 1'b0, 1'b0, CtlFree, "ls_c1");
    check("ls_stall_cnt", 32'(stall_cnt), 32'(1));
    check("ls_state_run", 32'(dut.state_q), 32'(StRun));

    // Flush wins over load stall
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, CtlFlush, "fl_ctl");
    check("fl_flush_cnt", 32'(flush_cnt), 32'(1));
    check("fl_stall_cnt", 32'(stall_cnt), 32'(0));
    check("fl_state", 32'(dut.state_q), 32'(StRun));

    // Freeze wins over flush, then flush on release
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, CtlFreeze, "fz_ctl");
    cyc(1'b0, 1'b1, 1'b0, CtlFlush, "fz_release");
    check("fz_stall_cnt", 32'(stall_cnt), 32'(3));
    check("fz_flush_cnt", 32'(flush_cnt), 32'(1));
    check("fz_state", 32'(dut.state_q), 32'(StRun));

    // Memory timeout after four busy cycles
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, CtlFreeze, "to_wait");
    check("to_err_early", 32'(mem_err), 32'(0));
    cyc(1'b0, 1'b0, 1'b1, CtlFreeze, "to_wait4");
    check("to_state", 32'(dut.state_q), 32'(StErr));
    check("to_mem_err", 32'(mem_err), 32'(1));
    cyc(1'b0, 1'b0, 1'b1, CtlErr, "to_err_busy");
    cyc(1'b0, 1'b0, 1'b0, CtlErr, "to_err_idle");
    cyc(1'b1, 1'b1, 1'b0, CtlErr, "to_err_req");
    check("to_hold_state", 32'(dut.state_q), 32'(StErr));
    check("to_stall_cnt", 32'(stall_cnt), 32'(4));
    check("to_flush_cnt", 32'(flush_cnt), 32'(0));
    do_reset();
    check("to_rst_err", 32'(mem_err), 32'(0));
    check("to_rst_state", 32'(dut.state_q), 32'(StRun));
    cyc(1'b0, 1'b0, 1'b0, CtlFree, "to_rst_ctl");

    // Asynchronous reset during the second busy cycle
    cyc(1'b0, 1'b0, 1'b1, CtlFreeze, "rm_busy1");
    drive(1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rm_state", 32'(dut.state_q), 32'(StRun));
    check("rm_cnt", 32'({stall_cnt, flush_cnt}), 32'(0));
    check("rm_err", 32'(mem_err), 32'(0));
    bus.dmem_busy = 1'b0;
    #1;
    check("rm_ctl", 32'(ctl), 32'(CtlFree));
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, CtlFree, "rm_after");

    // Saturation: ten stall cycles on a 3-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? CtlLstall : CtlFree, "sat_ctl");
      if (i == 11) check("sat_mid", 32'(stall_cnt), 32'(6));
      if (i == 13) check("sat_seven", 32'(stall_cnt), 32'(7));
    end
    check("sat_hold", 32'(stall_cnt), 32'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
